// File: rtl/fft_drain_if.sv
// fft_drain_if -- bus bundle between a row source, the drain and a serial sink.
//
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may change freely and the producer
// must not wait for ready before raising valid.
//
// Signals
//   in_vld   row valid from core readout         (source -> drain)
//   in_rdy   drain accepts the row this cycle     (drain  -> source)
//   in_data  8 lanes of DW bits, lane k = [k]     (source -> drain)
//   out_vld  serial sample valid                  (drain  -> sink)
//   out_rdy  sink accepts the sample              (sink   -> drain)
//   out_data serial sample                        (drain  -> sink)
//   out_last final sample of the frame            (drain  -> sink)
interface fft_drain_if #(
  parameter int DW = 64
);
  logic                 in_vld;
  logic                 in_rdy;
  logic [7:0][DW-1:0]   in_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [DW-1:0]        out_data;
  logic                 out_last;

  // The drain itself.
  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_last
  );

  // Row source plus serial sink (the environment around the drain).
  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_last
  );
endinterface

// File: rtl/fft_drain.sv
// fft_drain -- buffers 8-lane FFT result rows in a small FIFO and serialises
// them one sample per handshake, framing FRAME_ROWS rows per ARM request.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_arm        one-cycle request to drain one frame (honoured only in IDLE)
//   bus          fft_drain_if.slave: row input and serial output handshakes
//   o_busy       high while the FSM is in RUN
//   o_frame_done registered one-cycle pulse after the final sample handshake
//   o_state      FSM state for observation (0 = IDLE, 1 = RUN)
module fft_drain #(
  parameter int DW         = 64,
  parameter int FRAME_ROWS = 512,
  parameter int DEPTH      = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_arm,
  fft_drain_if.slave   bus,
  output logic         o_busy,
  output logic         o_frame_done,
  output logic         o_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(FRAME_ROWS + 1);
  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [RW-1:0] C_ROWS     = RW'(FRAME_ROWS);
  localparam logic [RW-1:0] C_LAST_ROW = RW'(FRAME_ROWS - 1);

  state_t r_state;
  state_t w_next;

  // Row storage is never reset; reads are gated by the occupancy count.
  logic [7:0][DW-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [RW-1:0] r_rows_in;
  logic [RW-1:0] r_rows_out;
  logic [2:0]    r_lane;
  logic          r_frame_done;

  logic               w_run;
  logic               w_start;
  logic               w_in_rdy;
  logic               w_out_vld;
  logic               w_out_last;
  logic               w_push;
  logic               w_out_hs;
  logic               w_pop;
  logic               w_final;
  logic [7:0][DW-1:0] w_head;

  assign w_run   = (r_state == ST_RUN);
  assign w_start = (r_state == ST_IDLE) && i_arm;

  // in_rdy looks only at registered state, never at out_rdy: a full FIFO
  // refuses a row even in a cycle where the head row is popped.
  assign w_in_rdy   = w_run && (r_count < C_DEPTH) && (r_rows_in < C_ROWS);
  assign w_out_vld  = w_run && (r_count != '0);
  assign w_out_last = w_out_vld && (r_rows_out == C_LAST_ROW) && (r_lane == 3'd7);

  assign w_push   = bus.in_vld && w_in_rdy;
  assign w_out_hs = w_out_vld && bus.out_rdy;
  assign w_pop    = w_out_hs && (r_lane == 3'd7);
  assign w_final  = w_out_hs && w_out_last;

  assign w_head = r_mem[r_rd_ptr];

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_vld  = w_out_vld;
  assign bus.out_last = w_out_last;
  // Forced to zero when not valid so the output never shows stale or unwritten storage.
  assign bus.out_data = w_out_vld ? w_head[r_lane] : '0;

  assign o_busy       = w_run;
  assign o_frame_done = r_frame_done;
  assign o_state      = r_state;

  // Next-state logic. An ARM arriving while in RUN, including on the final
  // handshake, is dropped: the block always passes through IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_arm)   w_next = ST_RUN;
      ST_RUN:  if (w_final) w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rows_in  <= '0;
      r_rows_out <= '0;
      r_lane     <= '0;
    end else if (w_start) begin
      // Starting a frame discards anything left behind by an earlier one.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rows_in  <= '0;
      r_rows_out <= '0;
      r_lane     <= '0;
    end else if (w_run) begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        // in_rdy is low once FRAME_ROWS rows are in, so this saturates.
        r_rows_in <= r_rows_in + RW'(1);
      end
      if (w_out_hs) r_lane <= r_lane + 3'd1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_rows_out <= r_rows_out + RW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_frame_done <= 1'b0;
    else       r_frame_done <= w_final;
  end

endmodule

// File: tb/tb_fft_drain.sv
module tb_fft_drain;
  localparam int DW      = 64;
  localparam int ROWS    = 512;
  localparam int DEPTH   = 4;
  localparam int SAMPLES = ROWS * 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic arm;
  logic busy;
  logic frame_done;
  logic state;

  always #5 clk = ~clk;

  fft_drain_if #(.DW(DW)) bus ();

  fft_drain #(.DW(DW), .FRAME_ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_arm        (arm),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_state      (state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_done   = 0;
  int next_row = 0;
  bit rand_data = 1'b0;
  logic [DW-1:0] data_base = '0;
  logic [7:0][DW-1:0] cur_row;

  // Output side: every sample handshake pops the queue; idle output must be zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.out_vld !== 1'b1) begin
        n_checks++;
        if (bus.out_data !== '0 || bus.out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_out: data=%0h last=%b required data=0 last=0", bus.out_data, bus.out_last);
        end
      end else if (bus.out_rdy === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sample_extra: got %0h with no sample expected", bus.out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_fail++;
            $display("FAIL sample_data #%0d: got %0h required %0h", n_out, bus.out_data, e);
          end
        end
        n_checks++;
        if (bus.out_last !== (n_out == SAMPLES - 1)) begin
          n_fail++;
          $display("FAIL out_last #%0d: got %b required %b", n_out, bus.out_last, (n_out == SAMPLES - 1));
        end
        n_out++;
      end
      if (frame_done === 1'b1) n_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_row();
    for (int k = 0; k < 8; k++)
      cur_row[k] = rand_data ? {$urandom, $urandom} : data_base + DW'(next_row * 8 + k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle of stimulus; an accepted row is pushed lane by lane.
  task automatic cycle(input bit vld, input bit rdy, input bit a);
    bus.in_vld  = vld;
    bus.in_data = cur_row;
    bus.out_rdy = rdy;
    arm         = a;
    @(negedge clk);
    if (vld && bus.in_rdy === 1'b1) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(cur_row[k]);
      next_row++;
      load_row();
    end
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic start_frame();
    n_out    = 0;
    n_done   = 0;
    next_row = 0;
    load_row();
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // Runs until FRAME_DONE is seen (or a cycle budget expires).
  task automatic feed(input int vld_pct, input int rdy_pct, input bit arm_last, output int cyc);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 20000) begin
      bit v;
      bit r;
      bit a;
      v = (next_row < ROWS) && ($urandom_range(99) < vld_pct);
      r = $urandom_range(99) < rdy_pct;
      a = 1'b0;
      if (arm_last && bus.out_last === 1'b1) begin
        r = 1'b1;
        a = 1'b1;
      end
      cycle(v, r, a);
      cyc++;
    end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_timeout: frame_done=%b after %0d cycles, required 1", frame_done, cyc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    arm = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({bus.in_rdy, bus.out_vld, bus.out_last, busy, frame_done, state} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_rdy,out_vld,last,busy,done,state=%b required 000000",
               {bus.in_rdy, bus.out_vld, bus.out_last, busy, frame_done, state});
    end
    n_checks++;
    if (bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h required 0", bus.out_data);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b state=%b required 0 0", busy, state);
    end
  endtask

  task automatic test_idle_gating();
    next_row = 0;
    load_row();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_gating: in_rdy=%b out_vld=%b required 0 0", bus.in_rdy, bus.out_vld);
      end
    end
    n_checks++;
    if (next_row != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_accept: rows accepted=%0d required 0", next_row);
    end
  endtask

  task automatic test_basic_frame();
    int cyc;
    rand_data = 1'b0;
    data_base = '0;
    start_frame();
    n_checks++;
    if (busy !== 1'b1 || state !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b state=%b required 1 1", busy, state);
    end
    feed(100, 100, 1'b0, cyc);
    n_checks++;
    if (cyc != SAMPLES + 1) begin
      n_fail++;
      $display("FAIL basic_cycles: frame_done after %0d cycles required %0d", cyc, SAMPLES + 1);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_fall: busy=%b with frame_done, required 0", busy);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (frame_done !== 1'b0 || n_done != 1 || n_out != SAMPLES || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_end: done=%b pulses=%0d samples=%0d left=%0d required 0 1 %0d 0",
               frame_done, n_done, n_out, exp_q.size(), SAMPLES);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    data_base = 64'h0000_0001_0000_0000;
    start_frame();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.out_vld !== 1'b1 || bus.out_data !== data_base) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: vld=%b data=%0h required 1 %0h", i, bus.out_vld, bus.out_data, data_base);
      end
    end
    n_checks++;
    if (next_row != DEPTH || bus.in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: rows=%0d in_rdy=%b required %0d 0", next_row, bus.in_rdy, DEPTH);
    end
    feed(100, 100, 1'b0, cyc);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_done != 1 || n_out != SAMPLES || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_end: pulses=%0d samples=%0d left=%0d required 1 %0d 0", n_done, n_out, exp_q.size(), SAMPLES);
    end
  endtask

  task automatic test_push_pop();
    int cyc;
    data_base = 64'h0000_0002_0000_0000;
    start_frame();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);          // push and pop with three rows held
    n_checks++;
    if (next_row != 4 || bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_count3: rows=%0d in_rdy=%b required 4 1", next_row, bus.in_rdy);
    end
    cycle(1'b1, 1'b0, 1'b0);          // fourth row fills the FIFO
    n_checks++;
    if (next_row != 5 || bus.in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_fill: rows=%0d in_rdy=%b required 5 0", next_row, bus.in_rdy);
    end
    repeat (7) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);          // pop while full: push must be refused
    n_checks++;
    if (next_row != 5 || bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_full_pop: rows=%0d in_rdy=%b required 5 1", next_row, bus.in_rdy);
    end
    feed(100, 100, 1'b0, cyc);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_done != 1 || n_out != SAMPLES || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pp_end: pulses=%0d samples=%0d left=%0d required 1 %0d 0", n_done, n_out, exp_q.size(), SAMPLES);
    end
  endtask

  task automatic test_rearm();
    int cyc;
    data_base = 64'h0000_0003_0000_0000;
    start_frame();
    repeat (50) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);          // ARM while running
    feed(100, 100, 1'b1, cyc);        // and again on the final handshake
    n_checks++;
    if (n_out != SAMPLES) begin
      n_fail++;
      $display("FAIL rearm_len: samples=%0d required %0d", n_out, SAMPLES);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (busy !== 1'b0 || bus.out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL rearm_idle cycle %0d: busy=%b out_vld=%b required 0 0", i, busy, bus.out_vld);
      end
    end
    n_checks++;
    if (n_done != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rearm_end: pulses=%0d left=%0d required 1 0", n_done, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int guard;
    data_base = 64'h0000_0004_0000_0000;
    start_frame();
    guard = 0;
    while (n_out < 5 && guard < 50) begin
      cycle(1'b1, 1'b1, 1'b0);
      guard++;
    end
    n_checks++;
    if (n_out != 5) begin
      n_fail++;
      $display("FAIL rm_prefix: samples=%0d required 5", n_out);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_rdy, bus.out_vld, bus.out_last, busy, frame_done, state} !== 6'b0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL rm_async: flags=%b data=%0h required 000000 0",
               {bus.in_rdy, bus.out_vld, bus.out_last, busy, frame_done, state}, bus.out_data);
    end
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    next_row = 0;
    load_row();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rm_idle cycle %0d: in_rdy=%b out_vld=%b busy=%b required 0 0 0", i, bus.in_rdy, bus.out_vld, busy);
      end
    end
    data_base = 64'h0000_0005_0000_0000;
    start_frame();
    cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_vld !== 1'b1 || bus.out_data !== data_base) begin
      n_fail++;
      $display("FAIL rm_restart: vld=%b data=%0h required 1 %0h", bus.out_vld, bus.out_data, data_base);
    end
    feed(100, 100, 1'b0, cyc);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_done != 1 || n_out != SAMPLES || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rm_end: pulses=%0d samples=%0d left=%0d required 1 %0d 0", n_done, n_out, exp_q.size(), SAMPLES);
    end
  endtask

  task automatic test_random_frame();
    int cyc;
    rand_data = 1'b1;
    start_frame();
    feed(70, 60, 1'b0, cyc);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (n_done != 1 || n_out != SAMPLES || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_end: pulses=%0d samples=%0d left=%0d required 1 %0d 0", n_done, n_out, exp_q.size(), SAMPLES);
    end
    rand_data = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_gating();
    test_basic_frame();
    test_backpressure();
    test_push_pop();
    test_rearm();
    test_reset_mid();
    test_random_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
